// File: rtl/rv32m_pkg.sv
// Shared types for the RV32M divide unit: operation encoding, FSM states
// and small op-decode helpers.
package rv32m_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Conditional two's-complement negate: takes |x| of signed operands on the way
// in and restores quotient/remainder signs on the way out.
module div_sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with
// valid/ready handshakes on both the operand and result sides.
module div_unit
  import rv32m_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  div_op_e               op,
  input  logic [DATA_WIDTH-1:0] alu_src_a,
  input  logic [DATA_WIDTH-1:0] alu_src_b,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state;
  logic [CW-1:0]         count;
  div_op_e               op_q;
  logic                  quo_neg_q;
  logic                  rem_neg_q;
  logic                  special_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dvs_q;

  logic                  in_signed;
  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic [DATA_WIDTH-1:0] special_result;

  assign in_signed = op_is_signed(op);
  assign div_zero  = (alu_src_b == '0);
  assign overflow  = in_signed && (alu_src_a == MIN_INT) && (alu_src_b == '1);

  div_sign_fixup #(.WIDTH(DATA_WIDTH)) u_abs_a (
    .value  (alu_src_a),
    .negate (in_signed && alu_src_a[DATA_WIDTH-1]),
    .result (a_abs)
  );

  div_sign_fixup #(.WIDTH(DATA_WIDTH)) u_abs_b (
    .value  (alu_src_b),
    .negate (in_signed && alu_src_b[DATA_WIDTH-1]),
    .result (b_abs)
  );

  // Divide-by-zero and signed overflow skip the iteration entirely.
  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = op_is_rem(op) ? alu_src_a : '1;
    else if (overflow)
      special_result = op_is_rem(op) ? '0 : MIN_INT;
  end

  // One restoring step; the partial remainder needs one extra bit after the shift.
  logic [DATA_WIDTH:0]   rem_shift;
  logic                  rem_ge;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] quo_fixed;
  logic [DATA_WIDTH-1:0] rem_fixed;

  assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_next  = rem_ge ? DATA_WIDTH'(rem_shift - {1'b0, dvs_q})
                            : rem_shift[DATA_WIDTH-1:0];
  assign quo_next  = {quo_q[DATA_WIDTH-2:0], rem_ge};

  div_sign_fixup #(.WIDTH(DATA_WIDTH)) u_fix_quo (
    .value  (quo_next),
    .negate (quo_neg_q),
    .result (quo_fixed)
  );

  div_sign_fixup #(.WIDTH(DATA_WIDTH)) u_fix_rem (
    .value  (rem_next),
    .negate (rem_neg_q),
    .result (rem_fixed)
  );

  // Special cases still pass through CALC for one cycle so every op has a uniform
  // accept -> CALC -> DONE path; their answer waits in quo_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      start_ready  <= 1'b1;
      op_q         <= DIV;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      special_q    <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
    end else if (flush) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
      start_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            op_q        <= op;
            quo_neg_q   <= in_signed && (alu_src_a[DATA_WIDTH-1] ^ alu_src_b[DATA_WIDTH-1]);
            rem_neg_q   <= in_signed && alu_src_a[DATA_WIDTH-1];
            special_q   <= div_zero || overflow;
            rem_q       <= '0;
            quo_q       <= (div_zero || overflow) ? special_result : a_abs;
            dvs_q       <= b_abs;
            count       <= '0;
            state       <= CALC;
            start_ready <= 1'b0;
          end
        end
        CALC: begin
          if (special_q) begin
            result       <= quo_q;
            state        <= DONE;
            result_valid <= 1'b1;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + CW'(1);
            if (count == LAST_COUNT) begin
              result       <= op_is_rem(op_q) ? rem_fixed : quo_fixed;
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          start_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
